// File: rtl/lsm_sequencer.sv
// lsm_sequencer: load/store-multiple register-list sequencer.
// Holds the LDM/STM register list, presents the lowest pending register,
// retires registers lowest-first, and derives start / write-back offsets
// from the latched P/U bits.
// Optional build macro: LSM_EMPTY_R15_EN -- an empty list loads R15 only
// with a count of 16 (ARMv4 empty-list behaviour).
module lsm_sequencer #(
    parameter int unsigned LIST_W = 16,
    parameter int unsigned OFS_W  = 32
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic [31:0]      IR,
    input  logic             LSM_EN,
    input  logic [2:0]       LSM_IN,
    output logic             LSM_DETECT,
    output logic             LSM_END,
    output logic [3:0]       REG_NUM,
    output logic [4:0]       COUNT,
    output logic [OFS_W-1:0] START_OFS,
    output logic [OFS_W-1:0] WB_OFS
);

    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_NEXT  = 3'd2;
    localparam logic [2:0] CMD_CLEAR = 3'd3;

    logic [LIST_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              p_q, p_d;
    logic              u_q, u_d;

    logic [LIST_W-1:0] ir_list;
    logic [CNT_W-1:0]  ir_list_cnt;
    logic [LIST_W-1:0] pending_drop;
    logic [OFS_W-1:0]  ofs_4n;
    logic [OFS_W-1:0]  ofs_four;
    logic              unused_ir;

    assign ir_list   = IR[LIST_W-1:0];
    assign unused_ir = ^{IR[31:25], IR[22:LIST_W]};

    // Pending list with its lowest set bit retired (zero stays zero)
    assign pending_drop = pending_q & (pending_q - LIST_W'(1));

    // Population count of the incoming register list
    always_comb begin
        ir_list_cnt = '0;
        for (int i = 0; i < int'(LIST_W); i++) begin
            ir_list_cnt = ir_list_cnt + CNT_W'(ir_list[i]);
        end
    end

    // Command decode: LOAD / NEXT / CLEAR, everything else holds
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        p_d       = p_q;
        u_d       = u_q;
        if (LSM_EN) begin
            case (LSM_IN)
                CMD_LOAD: begin
                    pending_d = ir_list;
                    count_d   = ir_list_cnt;
                    p_d       = IR[24];
                    u_d       = IR[23];
`ifdef LSM_EMPTY_R15_EN
                    if (ir_list == '0) begin
                        pending_d = LIST_W'(1) << (LIST_W - 1);
                        count_d   = CNT_W'(LIST_W);
                    end
`endif
                end
                CMD_NEXT:  pending_d = pending_drop;
                CMD_CLEAR: pending_d = '0;
                default:   ;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            pending_q <= '0;
            count_q   <= '0;
            p_q       <= 1'b0;
            u_q       <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            p_q       <= p_d;
            u_q       <= u_d;
        end
    end

    assign LSM_DETECT = |pending_q;
    assign LSM_END    = LSM_DETECT && !(|pending_drop);
    assign COUNT      = count_q;

    // Index of the lowest pending register (0 when nothing pending)
    always_comb begin
        REG_NUM = '0;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                REG_NUM = 4'(i);
            end
        end
    end

    assign ofs_4n   = OFS_W'(count_q) << 2;
    assign ofs_four = OFS_W'(4);

    // Address offsets per addressing mode; an empty transfer moves nothing
    always_comb begin
        START_OFS = '0;
        WB_OFS    = '0;
        if (count_q != '0) begin
            case ({p_q, u_q})
                2'b01: begin START_OFS = '0;                WB_OFS = ofs_4n;      end
                2'b11: begin START_OFS = ofs_four;          WB_OFS = ofs_4n;      end
                2'b00: begin START_OFS = ofs_four - ofs_4n; WB_OFS = '0 - ofs_4n; end
                default: begin START_OFS = '0 - ofs_4n;     WB_OFS = '0 - ofs_4n; end
            endcase
        end
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// tb_lsm_sequencer: scoreboard bench for lsm_sequencer.
// Honours LSM_EMPTY_R15_EN when compiled with it.
module tb_lsm_sequencer;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic [31:0] IR;
    logic        LSM_EN;
    logic [2:0]  LSM_IN;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic [3:0]  REG_NUM;
    logic [4:0]  COUNT;
    logic [31:0] START_OFS;
    logic [31:0] WB_OFS;

    typedef struct {
        logic        det;
        logic        fin;
        logic [3:0]  rn;
        logic [4:0]  cnt;
        logic [31:0] so;
        logic [31:0] wo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] m_pend;
    logic [4:0]  m_cnt;
    logic        m_p;
    logic        m_u;

    lsm_sequencer #(.LIST_W(16), .OFS_W(32)) dut (
        .CLK        (CLK),
        .CLR_N      (CLR_N),
        .IR         (IR),
        .LSM_EN     (LSM_EN),
        .LSM_IN     (LSM_IN),
        .LSM_DETECT (LSM_DETECT),
        .LSM_END    (LSM_END),
        .REG_NUM    (REG_NUM),
        .COUNT      (COUNT),
        .START_OFS  (START_OFS),
        .WB_OFS     (WB_OFS)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_ir(input logic p, input logic u, input logic [15:0] list);
        return {7'd0, p, u, 7'd0, list};
    endfunction

    function automatic logic [15:0] clear_low(input logic [15:0] v);
        logic [15:0] r;
        logic        done;
        r    = v;
        done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!done && v[i]) begin
                r[i] = 1'b0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   n4;
        logic found;
        e.det = (m_pend != 16'd0);
        e.fin = ($countones(m_pend) == 1);
        e.rn  = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && m_pend[i]) begin
                e.rn  = 4'(i);
                found = 1'b1;
            end
        end
        e.cnt = m_cnt;
        n4    = 4 * int'(m_cnt);
        if (m_cnt == 5'd0) begin
            e.so = 32'd0;
            e.wo = 32'd0;
        end else begin
            case ({m_p, m_u})
                2'b01:   begin e.so = 32'd0;        e.wo = 32'(n4);  end
                2'b11:   begin e.so = 32'd4;        e.wo = 32'(n4);  end
                2'b00:   begin e.so = 32'(4 - n4);  e.wo = 32'(-n4); end
                default: begin e.so = 32'(-n4);     e.wo = 32'(-n4); end
            endcase
        end
        return e;
    endfunction

    // Drive one command for one rising edge and queue the expected outcome
    task automatic drive(input logic en, input logic [2:0] cmd, input logic [31:0] ir);
        @(negedge CLK);
        LSM_EN = en;
        LSM_IN = cmd;
        IR     = ir;
        if (en) begin
            case (cmd)
                3'd1: begin
                    m_pend = ir[15:0];
                    m_cnt  = 5'($countones(ir[15:0]));
                    m_p    = ir[24];
                    m_u    = ir[23];
`ifdef LSM_EMPTY_R15_EN
                    if (ir[15:0] == 16'd0) begin
                        m_pend = 16'h8000;
                        m_cnt  = 5'd16;
                    end
`endif
                end
                3'd2:    m_pend = clear_low(m_pend);
                3'd3:    m_pend = 16'd0;
                default: ;
            endcase
        end
        sb.push_back(model_out());
        @(posedge CLK);
        #2;
        LSM_EN = 1'b0;
        LSM_IN = 3'd0;
    endtask

    // Scoreboard: compare each queued expectation just after its edge
    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (LSM_DETECT !== mon_e.det) begin
                errors++;
                $display("FAIL sb_detect t=%0t got=%b exp=%b", $time, LSM_DETECT, mon_e.det);
            end
            checks++;
            if (LSM_END !== mon_e.fin) begin
                errors++;
                $display("FAIL sb_end t=%0t got=%b exp=%b", $time, LSM_END, mon_e.fin);
            end
            checks++;
            if (REG_NUM !== mon_e.rn) begin
                errors++;
                $display("FAIL sb_reg_num t=%0t got=%0d exp=%0d", $time, REG_NUM, mon_e.rn);
            end
            checks++;
            if (COUNT !== mon_e.cnt) begin
                errors++;
                $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, COUNT, mon_e.cnt);
            end
            checks++;
            if (START_OFS !== mon_e.so) begin
                errors++;
                $display("FAIL sb_start_ofs t=%0t got=%h exp=%h", $time, START_OFS, mon_e.so);
            end
            checks++;
            if (WB_OFS !== mon_e.wo) begin
                errors++;
                $display("FAIL sb_wb_ofs t=%0t got=%h exp=%h", $time, WB_OFS, mon_e.wo);
            end
        end
    end

    task automatic model_reset();
        m_pend = 16'd0;
        m_cnt  = 5'd0;
        m_p    = 1'b0;
        m_u    = 1'b0;
    endtask

    task automatic test_reset();
        CLR_N  = 1'b0;
        LSM_EN = 1'b0;
        LSM_IN = 3'd0;
        IR     = 32'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({LSM_DETECT, LSM_END, REG_NUM, COUNT} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags got=%b/%b/%0d/%0d exp=0/0/0/0", LSM_DETECT, LSM_END, REG_NUM, COUNT);
        end
        checks++;
        if (START_OFS !== 32'd0 || WB_OFS !== 32'd0) begin
            errors++;
            $display("FAIL reset_offsets got=%h/%h exp=0/0", START_OFS, WB_OFS);
        end
        @(negedge CLK);
        CLR_N = 1'b1;
    endtask

    task automatic test_ia();
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'h8005));
        checks++;
        if (REG_NUM !== 4'd0 || COUNT !== 5'd3) begin
            errors++;
            $display("FAIL ia_load got reg=%0d cnt=%0d exp reg=0 cnt=3", REG_NUM, COUNT);
        end
        checks++;
        if (START_OFS !== 32'd0 || WB_OFS !== 32'd12) begin
            errors++;
            $display("FAIL ia_offsets got=%h/%h exp=0/c", START_OFS, WB_OFS);
        end
        drive(1'b1, 3'd2, 32'd0);
        checks++;
        if (REG_NUM !== 4'd2) begin
            errors++;
            $display("FAIL ia_next1 got=%0d exp=2", REG_NUM);
        end
        drive(1'b1, 3'd2, 32'd0);
        checks++;
        if (REG_NUM !== 4'd15 || LSM_END !== 1'b1) begin
            errors++;
            $display("FAIL ia_next2 got reg=%0d end=%b exp reg=15 end=1", REG_NUM, LSM_END);
        end
        drive(1'b1, 3'd2, 32'd0);
        checks++;
        if (LSM_DETECT !== 1'b0) begin
            errors++;
            $display("FAIL ia_done got=%b exp=0", LSM_DETECT);
        end
    endtask

    task automatic test_db_da();
        drive(1'b1, 3'd1, mk_ir(1'b1, 1'b0, 16'h00F0));
        checks++;
        if (COUNT !== 5'd4 || START_OFS !== 32'hFFFF_FFF0 || WB_OFS !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL db_offsets got cnt=%0d so=%h wo=%h exp 4/fffffff0/fffffff0", COUNT, START_OFS, WB_OFS);
        end
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b0, 16'h00F0));
        checks++;
        if (START_OFS !== 32'hFFFF_FFF4 || WB_OFS !== 32'hFFFF_FFF0) begin
            errors++;
            $display("FAIL da_offsets got so=%h wo=%h exp fffffff4/fffffff0", START_OFS, WB_OFS);
        end
    endtask

    task automatic test_enable();
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'h0A0A));
        repeat (3) drive(1'b0, 3'd2, 32'd0);
        checks++;
        if (REG_NUM !== 4'd1) begin
            errors++;
            $display("FAIL en_gate got=%0d exp=1", REG_NUM);
        end
        drive(1'b1, 3'd5, mk_ir(1'b1, 1'b0, 16'h0001));
        drive(1'b1, 3'd7, 32'd0);
        checks++;
        if (REG_NUM !== 4'd1 || COUNT !== 5'd4 || WB_OFS !== 32'd16) begin
            errors++;
            $display("FAIL en_reserved got reg=%0d cnt=%0d wo=%h exp 1/4/10", REG_NUM, COUNT, WB_OFS);
        end
    endtask

    task automatic test_full();
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'hFFFF));
        checks++;
        if (COUNT !== 5'd16 || WB_OFS !== 32'd64) begin
            errors++;
            $display("FAIL full_load got cnt=%0d wo=%h exp 16/40", COUNT, WB_OFS);
        end
        repeat (15) drive(1'b1, 3'd2, 32'd0);
        checks++;
        if (REG_NUM !== 4'd15 || LSM_END !== 1'b1) begin
            errors++;
            $display("FAIL full_last got reg=%0d end=%b exp 15/1", REG_NUM, LSM_END);
        end
        drive(1'b1, 3'd3, 32'd0);
        checks++;
        if (LSM_DETECT !== 1'b0 || WB_OFS !== 32'd64) begin
            errors++;
            $display("FAIL full_clear got det=%b wo=%h exp 0/40", LSM_DETECT, WB_OFS);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'h0003));
        drive(1'b1, 3'd1, mk_ir(1'b1, 1'b1, 16'h0300));
        checks++;
        if (REG_NUM !== 4'd8 || COUNT !== 5'd2 || START_OFS !== 32'd4) begin
            errors++;
            $display("FAIL b2b_reload got reg=%0d cnt=%0d so=%h exp 8/2/4", REG_NUM, COUNT, START_OFS);
        end
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'h0001));
        drive(1'b1, 3'd2, 32'd0);
        drive(1'b1, 3'd2, 32'd0);
        checks++;
        if (LSM_DETECT !== 1'b0 || REG_NUM !== 4'd0 || COUNT !== 5'd1) begin
            errors++;
            $display("FAIL next_on_empty got det=%b reg=%0d cnt=%0d exp 0/0/1", LSM_DETECT, REG_NUM, COUNT);
        end
    endtask

    task automatic test_empty();
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'h0000));
`ifdef LSM_EMPTY_R15_EN
        checks++;
        if (REG_NUM !== 4'd15 || LSM_END !== 1'b1 || COUNT !== 5'd16 || WB_OFS !== 32'd64) begin
            errors++;
            $display("FAIL empty_r15 got reg=%0d end=%b cnt=%0d wo=%h exp 15/1/16/40", REG_NUM, LSM_END, COUNT, WB_OFS);
        end
`else
        checks++;
        if (LSM_DETECT !== 1'b0 || COUNT !== 5'd0 || WB_OFS !== 32'd0) begin
            errors++;
            $display("FAIL empty_skip got det=%b cnt=%0d wo=%h exp 0/0/0", LSM_DETECT, COUNT, WB_OFS);
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  cmd;
        logic [15:0] list;
        for (int k = 0; k < 60; k++) begin
            cmd  = 3'($urandom_range(0, 7));
            list = 16'($urandom);
            if (k % 9 == 0) list = 16'd0;
            drive(1'($urandom_range(0, 3) != 0), cmd,
                  mk_ir(1'($urandom), 1'($urandom), list));
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd1, mk_ir(1'b0, 1'b1, 16'h00FF));
        drive(1'b1, 3'd2, 32'd0);
        @(posedge CLK);
        #3;
        CLR_N = 1'b0;
        #1;
        checks++;
        if (LSM_DETECT !== 1'b0 || COUNT !== 5'd0 || WB_OFS !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got det=%b cnt=%0d wo=%h exp 0/0/0", LSM_DETECT, COUNT, WB_OFS);
        end
        model_reset();
        @(negedge CLK);
        CLR_N = 1'b1;
        drive(1'b0, 3'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_ia();
        test_db_da();
        test_enable();
        test_full();
        test_back_to_back();
        test_empty();
        test_random();
        test_async_reset();
        repeat (2) @(posedge CLK);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
